// File: rtl/prog_sequencer_pkg.sv
// prog_sequencer_pkg
//   Shared definitions for the program sequencer: default widths, the
//   sequencer state type and the per-program base address table.
package prog_sequencer_pkg;

    localparam int DEF_PC_W       = 11;
    localparam int DEF_CYC_W      = 16;
    localparam int DEF_NUM_PROGS  = 3;
    localparam int DEF_START_HOLD = 2;
    localparam int DEF_WDOG_LIMIT = 1000;

    // Hold counter covers START_HOLD values 0..15.
    localparam int HOLD_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_HOLD   = 3'd2,
        S_RUN    = 3'd3,
        S_REPORT = 3'd4,
        S_FINISH = 3'd5
    } seq_state_t;

    // Base PC of each program.
    function automatic logic [10:0] base_pc(input logic [1:0] idx);
        case (idx)
            2'd0:    return 11'd0;
            2'd1:    return 11'd128;
            2'd2:    return 11'd256;
            default: return 11'd384;
        endcase
    endfunction

endpackage

// File: rtl/prog_sequencer_seq_cycle_counter.sv
// seq_cycle_counter
//   Saturating cycle counter with synchronous clear and enable, plus a
//   compare against a limit value.
//   Ports:
//     clk, reset     clock, synchronous active-high reset
//     clear          load zero (takes priority over enable)
//     enable         count up by one; holds at all-ones
//     limit          compare value for at_limit
//     count          current count (registered)
//     at_limit       count equals limit
module seq_cycle_counter
    import prog_sequencer_pkg::*;
#(
    parameter int CYC_W = DEF_CYC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CYC_W-1:0] limit,
    output logic [CYC_W-1:0] count,
    output logic             at_limit
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CYC_W'(1);
        end
    end

    always_comb begin
        at_limit = (count == limit);
    end

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer
//   Runs NUM_PROGS core programs back to back. For each program it strobes
//   a PC load to the program's base address, holds the fetch unit with
//   start for 1+START_HOLD cycles, counts RUN cycles until core_done and
//   reports the count with a one-cycle cyc_valid pulse.
//   Optional build macro: SEQ_WATCHDOG_EN -- aborts a program whose RUN
//   count reaches WDOG_LIMIT, reporting it with err alongside cyc_valid.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     go           level request to run the series (registered before use)
//     core_done    current program finished (only observed in RUN)
//     start        fetch hold request
//     load_pc      one-cycle PC load strobe, load_addr is the target
//     load_addr    base address of the current program
//     prog_idx     index of current/last program
//     busy         series in progress
//     all_done     series complete, waiting for go to drop
//     cyc_valid    cyc_count valid for prog_idx
//     cyc_count    RUN-cycle count of current/last program
//     err          watchdog abort, coincident with cyc_valid
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int PC_W       = DEF_PC_W,
    parameter int NUM_PROGS  = DEF_NUM_PROGS,
    parameter int CYC_W      = DEF_CYC_W,
    parameter int START_HOLD = DEF_START_HOLD,
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             core_done,
    output logic             start,
    output logic             load_pc,
    output logic [PC_W-1:0]  load_addr,
    output logic [1:0]       prog_idx,
    output logic             busy,
    output logic             all_done,
    output logic             cyc_valid,
    output logic [CYC_W-1:0] cyc_count,
    output logic             err
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);

`ifdef SEQ_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    // Without the watchdog the limit is all-ones and only marks saturation.
    // A watchdog limit beyond the counter range trips at saturation.
    localparam logic [CYC_W-1:0] CNT_LIMIT =
        (!WDOG_ON || (longint'(WDOG_LIMIT) > ((longint'(1) << CYC_W) - 1)))
            ? '1 : CYC_W'(WDOG_LIMIT);

    seq_state_t        state, nxt;
    logic [1:0]        nxt_idx;
    logic              go_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              cnt_clear, cnt_en, at_limit, wd_trip;

`ifdef SEQ_WATCHDOG_EN
    always_comb begin
        wd_trip = (state == S_RUN) && !core_done && at_limit;
    end
`else
    always_comb begin
        wd_trip = 1'b0;
    end
`endif

    always_comb begin
        nxt     = state;
        nxt_idx = prog_idx;
        case (state)
            S_IDLE: begin
                if (go_q) begin
                    nxt     = S_LOAD;
                    nxt_idx = '0;
                end
            end
            S_LOAD:   nxt = (START_HOLD == 0) ? S_RUN : S_HOLD;
            S_HOLD: begin
                if ((5'(hold_cnt) + 5'd1) == 5'(START_HOLD)) nxt = S_RUN;
            end
            S_RUN: begin
                if (core_done || wd_trip) nxt = S_REPORT;
            end
            S_REPORT: begin
                if (prog_idx == LAST_IDX) begin
                    nxt = S_FINISH;
                end else begin
                    nxt     = S_LOAD;
                    nxt_idx = prog_idx + 2'd1;
                end
            end
            S_FINISH: begin
                if (!go_q) nxt = S_IDLE;
            end
            default:  nxt = S_IDLE;
        endcase

        cnt_clear = (nxt == S_RUN) && (state != S_RUN);
        cnt_en    = (state == S_RUN) && !core_done && !at_limit;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            go_q      <= 1'b0;
            hold_cnt  <= '0;
            start     <= 1'b0;
            load_pc   <= 1'b0;
            load_addr <= '0;
            prog_idx  <= '0;
            busy      <= 1'b0;
            all_done  <= 1'b0;
            cyc_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= nxt;
            go_q      <= go;
            prog_idx  <= nxt_idx;
            start     <= (nxt == S_LOAD) || (nxt == S_HOLD);
            load_pc   <= (nxt == S_LOAD);
            busy      <= (nxt == S_LOAD) || (nxt == S_HOLD) ||
                         (nxt == S_RUN)  || (nxt == S_REPORT);
            all_done  <= (nxt == S_FINISH);
            cyc_valid <= (nxt == S_REPORT);
            err       <= wd_trip;
            if (nxt == S_LOAD) load_addr <= PC_W'(base_pc(nxt_idx));
            if (state == S_LOAD) begin
                hold_cnt <= '0;
            end else if (state == S_HOLD) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    seq_cycle_counter #(
        .CYC_W (CYC_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .limit    (CNT_LIMIT),
        .count    (cyc_count),
        .at_limit (at_limit)
    );

endmodule
